uart_tx_arbiter: RTL and testbench

Shares the single ISP-UART TX pin between two byte-stream requesters: requester 0 is the ISP responder and requester 1 is the user UART. It serialises 8N1 frames and arbitrates round-robin with line-granular locking, so text lines from the two sources never interleave. It sits inside soc_top between the two UART byte sources and the `isp_uart_tx` pad.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_serializer.sv | 89 ++++++++
 rtl/uart_tx_arbiter.sv | 108 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and constants for the UART TX arbiter slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_tx_state_t;

   localparam logic [7:0] UART_LF = 8'h0A;

   // A line feed terminates a text line and therefore ends the owner's lock.
   function automatic logic is_line_end(input logic [7:0] b);
      return (b == UART_LF);
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_serializer
//  Description : 8N1 frame serializer with byte-in/start/busy interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLK_DIV = 434
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       busy
);

   localparam int                  c_baud_w    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLK_DIV - 1);
   localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);

   uart_tx_state_t      r_state;
   logic [c_baud_w-1:0] r_baud_cnt;
   logic [2:0]          r_bit_idx;
   logic [7:0]          r_shift;
   logic                w_bit_end;

   assign w_bit_end = (r_baud_cnt == c_baud_last);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_baud_cnt <= '0;
         r_bit_idx  <= '0;
         r_shift    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_baud_cnt <= '0;
               r_bit_idx  <= '0;
               if (start) begin
                  r_shift <= data;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  r_shift   <= {1'b0, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // Bit-period counter free-runs only while a frame is on the line.
         if (r_state != S_IDLE) begin
            r_baud_cnt <= w_bit_end ? '0 : (r_baud_cnt + c_baud_one);
         end
      end
   end

   always_comb begin
      tx = 1'b1;
      case (r_state)
         S_START: tx = 1'b0;
         S_DATA:  tx = r_shift[0];
         default: tx = 1'b1;
      endcase
   end

   assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin, line-locked sharing of one UART TX pin.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int CLK_DIV      = 434,
   parameter int IDLE_RELEASE = 4096
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   input  logic [7:0] req0_data,
   output logic       req0_ready,
   input  logic       req1_valid,
   input  logic [7:0] req1_data,
   output logic       req1_ready,
   output logic       tx,
   output logic       busy,
   output logic       owner,
   output logic       locked
);

   localparam int                  c_idle_w    = $clog2(IDLE_RELEASE + 1);
   localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(IDLE_RELEASE - 1);
   localparam logic [c_idle_w-1:0] c_idle_one  = c_idle_w'(1);

   logic                r_owner;
   logic                r_locked;
   logic [c_idle_w-1:0] r_idle_cnt;

   logic                w_ser_busy;
   logic                w_sel0;
   logic                w_sel1;
   logic                w_ready0;
   logic                w_ready1;
   logic                w_accept;
   logic [7:0]          w_accept_data;
   logic                w_owner_valid;
   logic                w_idle_tick;

   // Locked: only the owner. Unlocked tie: the requester that did not go last.
   always_comb begin
      w_sel0 = 1'b0;
      w_sel1 = 1'b0;
      if (r_locked) begin
         w_sel0 = ~r_owner;
         w_sel1 = r_owner;
      end else if (req0_valid && req1_valid) begin
         w_sel0 = r_owner;
         w_sel1 = ~r_owner;
      end else begin
         w_sel0 = req0_valid;
         w_sel1 = req1_valid;
      end
   end

   assign w_ready0      = ~w_ser_busy & req0_valid & w_sel0;
   assign w_ready1      = ~w_ser_busy & req1_valid & w_sel1;
   assign w_accept      = w_ready0 | w_ready1;
   assign w_accept_data = w_ready1 ? req1_data : req0_data;
   assign w_owner_valid = r_owner ? req1_valid : req0_valid;
   assign w_idle_tick   = r_locked & ~w_ser_busy & ~w_owner_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_owner    <= 1'b1;
         r_locked   <= 1'b0;
         r_idle_cnt <= '0;
      end else if (w_accept) begin
         r_owner    <= w_ready1;
         r_locked   <= ~is_line_end(w_accept_data);
         r_idle_cnt <= '0;
      end else if (w_idle_tick) begin
         // Release on the tick that brings the count up to IDLE_RELEASE.
         if (r_idle_cnt == c_idle_last) begin
            r_locked   <= 1'b0;
            r_idle_cnt <= '0;
         end else begin
            r_idle_cnt <= r_idle_cnt + c_idle_one;
         end
      end else begin
         r_idle_cnt <= '0;
      end
   end

   uart_tx_serializer #(
      .CLK_DIV (CLK_DIV)
   ) u_serializer (
      .clk   (clk),
      .rst   (rst),
      .start (w_accept),
      .data  (w_accept_data),
      .tx    (tx),
      .busy  (w_ser_busy)
   );

   assign req0_ready = w_ready0;
   assign req1_ready = w_ready1;
   assign busy       = w_ser_busy;
   assign owner      = r_owner;
   assign locked     = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Scoreboard bench for uart_tx_arbiter with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int CLK_DIV      = 4;
   localparam int IDLE_RELEASE = 16;
   localparam int FRAME        = 10 * CLK_DIV;

   typedef struct {
      int         gap;
      logic [7:0] b;
   } src_t;

   typedef struct {
      logic [7:0] b;
      int         t;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req0_valid = 1'b0;
   logic [7:0] req0_data  = 8'h00;
   logic       req1_valid = 1'b0;
   logic [7:0] req1_data  = 8'h00;
   logic       req0_ready;
   logic       req1_ready;
   logic       tx;
   logic       busy;
   logic       owner;
   logic       locked;

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   src_t src0_q[$];
   src_t src1_q[$];
   exp_t exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_arbiter #(
      .CLK_DIV      (CLK_DIV),
      .IDLE_RELEASE (IDLE_RELEASE)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .tx         (tx),
      .busy       (busy),
      .owner      (owner),
      .locked     (locked)
   );

   task automatic check(input string name, input int act, input int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Reference model: grant decision, lock rules and frame occupancy in plain integers.
   int m_owner     = 1;
   bit m_locked    = 1'b0;
   int m_idle      = 0;
   int m_busy_left = 0;

   always @(negedge clk) begin : model_blk
      int         g;
      bit         vown;
      exp_t       e;
      logic [7:0] b;
      if (rst) begin
         m_owner     = 1;
         m_locked    = 1'b0;
         m_idle      = 0;
         m_busy_left = 0;
         exp_q.delete();
      end else begin
         g = -1;
         if (m_busy_left == 0) begin
            if (m_locked) begin
               if ((m_owner == 0 && req0_valid) || (m_owner == 1 && req1_valid)) g = m_owner;
            end else if (req0_valid && req1_valid) begin
               g = 1 - m_owner;
            end else if (req0_valid) begin
               g = 0;
            end else if (req1_valid) begin
               g = 1;
            end
         end
         check("req0_ready", int'(req0_ready), int'(g == 0));
         check("req1_ready", int'(req1_ready), int'(g == 1));
         check("busy", int'(busy), int'(m_busy_left != 0));
         check("owner", int'(owner), m_owner);
         check("locked", int'(locked), int'(m_locked));
         if (g >= 0) begin
            b   = (g == 0) ? req0_data : req1_data;
            e.b = b;
            e.t = cyc;
            exp_q.push_back(e);
            m_owner     = g;
            m_locked    = (b != 8'h0A);
            m_idle      = 0;
            m_busy_left = FRAME;
         end else begin
            vown = (m_owner == 0) ? req0_valid : req1_valid;
            if (m_locked && m_busy_left == 0 && !vown) begin
               m_idle++;
               if (m_idle == IDLE_RELEASE) begin
                  m_locked = 1'b0;
                  m_idle   = 0;
               end
            end else begin
               m_idle = 0;
            end
            if (m_busy_left > 0) m_busy_left--;
         end
      end
   end

   // Monitor: pops the expected byte when a frame begins and checks every tx cycle.
   bit         mon_active = 1'b0;
   int         mon_base   = 0;
   logic [7:0] mon_byte   = 8'h00;

   always @(negedge clk) begin : monitor_blk
      int   p;
      int   bit_no;
      int   eb;
      exp_t e;
      if (rst) begin
         mon_active = 1'b0;
      end else begin
         if (!mon_active && exp_q.size() != 0) begin
            if (tx == 1'b0 || cyc > exp_q[0].t + 1) begin
               e = exp_q.pop_front();
               check("frame_start", cyc, e.t + 1);
               mon_active = 1'b1;
               mon_base   = e.t + 1;
               mon_byte   = e.b;
            end
         end
         if (mon_active) begin
            p      = cyc - mon_base;
            bit_no = p / CLK_DIV;
            if (bit_no == 0)      eb = 0;
            else if (bit_no <= 8) eb = int'(mon_byte[bit_no-1]);
            else                  eb = 1;
            check("tx_bit", int'(tx), eb);
            if (p >= FRAME - 1) mon_active = 1'b0;
         end else begin
            check("tx_idle", int'(tx), 1);
         end
      end
   end

   // Driver: presents each queued byte after its gap and holds it until accepted.
   bit hs0 = 1'b0;
   bit hs1 = 1'b0;
   int w0  = 0;
   int w1  = 0;

   always @(negedge clk) begin
      hs0 = req0_valid & req0_ready & ~rst;
      hs1 = req1_valid & req1_ready & ~rst;
   end

   initial begin : driver_blk
      src_t tmp;
      forever begin
         @(posedge clk);
         #2;
         if (rst) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
         end else begin
            if (hs0) begin
               tmp = src0_q.pop_front();
               w0 = 0;
               req0_valid = 1'b0;
            end
            if (!req0_valid) begin
               req0_data = 8'($urandom);
               if (src0_q.size() != 0) begin
                  if (w0 >= src0_q[0].gap) begin
                     req0_valid = 1'b1;
                     req0_data  = src0_q[0].b;
                  end else begin
                     w0++;
                  end
               end
            end
            if (hs1) begin
               tmp = src1_q.pop_front();
               w1 = 0;
               req1_valid = 1'b0;
            end
            if (!req1_valid) begin
               req1_data = 8'($urandom);
               if (src1_q.size() != 0) begin
                  if (w1 >= src1_q[0].gap) begin
                     req1_valid = 1'b1;
                     req1_data  = src1_q[0].b;
                  end else begin
                     w1++;
                  end
               end
            end
         end
      end
   end

   task automatic push0(input int gap, input logic [7:0] b);
      src_t s;
      s.gap = gap;
      s.b   = b;
      src0_q.push_back(s);
   endtask

   task automatic push1(input int gap, input logic [7:0] b);
      src_t s;
      s.gap = gap;
      s.b   = b;
      src1_q.push_back(s);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic drain(input int budget, input string name);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (src0_q.size() == 0 && src1_q.size() == 0 && !req0_valid && !req1_valid &&
             !busy && exp_q.size() == 0 && !mon_active) break;
      end
      if (k >= budget) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: drain not reached within %0d cycles", name, budget);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin : main_blk
      int k;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_tx", int'(tx), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_owner", int'(owner), 1);
      check("reset_locked", int'(locked), 0);

      // Single byte
      push0(0, 8'h55);
      drain(200, "single");

      // Tie after reset
      do_reset();
      push0(0, 8'h0A);
      push1(0, 8'h0A);
      drain(300, "tie");

      // Line lock
      do_reset();
      push0(0, 8'h41);
      push0(0, 8'h42);
      push0(0, 8'h0A);
      push1(0, 8'h78);
      push1(0, 8'h79);
      push1(0, 8'h0A);
      drain(600, "line_lock");

      // Idle timeout
      do_reset();
      push0(0, 8'h41);
      push1(3, 8'h31);
      drain(400, "timeout");

      // Owner returns on the cycle the count would reach IDLE_RELEASE
      do_reset();
      push0(0, 8'h41);
      push0(55, 8'h42);
      push1(0, 8'h31);
      drain(600, "race");

      // Reset during data bit 3
      do_reset();
      push0(0, 8'h33);
      for (k = 0; k < 50; k++) begin
         @(negedge clk);
         if (req0_valid && req0_ready) break;
      end
      if (k >= 50) begin
         n_vec++;
         n_err++;
         $display("FAIL midreset_accept: no accept within 50 cycles");
      end
      repeat (18) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midreset_tx", int'(tx), 1);
      check("midreset_busy", int'(busy), 0);
      check("midreset_owner", int'(owner), 1);
      check("midreset_locked", int'(locked), 0);
      push0(0, 8'hA5);
      drain(200, "after_reset");

      // Randomized traffic from both sources
      do_reset();
      for (int i = 0; i < 40; i++) begin
         push0(($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 6)),
               ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom));
         push1(($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60)) : int'($urandom_range(0, 6)),
               ($urandom_range(0, 3) == 0) ? 8'h0A : 8'($urandom));
      end
      drain(20000, "random");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
